// File: rtl/or_gate_response_checker.sv
// Response monitor for a four-input OR gate: checks {e,f,g} against the golden
// function, tracks errors, first failure and coverage. Optional timeout: CHECKER_TIMEOUT_EN.
module or_gate_response_checker #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ERR_W          = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [3:0]       vec,
  input  logic             obs_e,
  input  logic             obs_f,
  input  logic             obs_g,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timed_out,
  output logic [ERR_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [3:0]       first_fail_vec,
  output logic [15:0]      seen_mask
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             first_fail_valid_q, first_fail_valid_d;
  logic [3:0]       first_fail_vec_q, first_fail_vec_d;
  logic [15:0]      seen_mask_q, seen_mask_d;

  logic             exp_e, exp_f, exp_g;
  logic             mismatch;
  logic             sample_en;
  logic             run_clear;
  logic             cov_done;
  logic             timeout_hit;
  logic [15:0]      vec_onehot;
  logic [15:0]      seen_next;

  assign exp_e      = vec[3] | vec[2];
  assign exp_f      = vec[1] | vec[0];
  assign exp_g      = |vec;
  assign mismatch   = (obs_e != exp_e) || (obs_f != exp_f) || (obs_g != exp_g);

  assign sample_en  = (state_q == ST_RUN) && vec_valid;
  assign run_clear  = (state_q != ST_RUN) && start;
  assign vec_onehot = 16'h0001 << vec;
  assign seen_next  = seen_mask_q | vec_onehot;
  assign cov_done   = sample_en && (seen_next == '1);

`ifdef CHECKER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic             timed_out_q, timed_out_d;

  // cyc_cnt_q holds the number of RUN edges already taken, so the
  // TIMEOUT_CYCLES-th RUN edge is the one where it equals CNT_LAST.
  assign timeout_hit = (state_q == ST_RUN) && (cyc_cnt_q == CNT_LAST);

  always_comb begin
    cyc_cnt_d   = cyc_cnt_q;
    timed_out_d = timed_out_q;
    if (run_clear) begin
      cyc_cnt_d   = '0;
      timed_out_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
      if (timeout_hit && !cov_done) begin
        timed_out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q   <= '0;
      timed_out_q <= 1'b0;
    end else begin
      cyc_cnt_q   <= cyc_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    err_count_d        = err_count_q;
    first_fail_valid_d = first_fail_valid_q;
    first_fail_vec_d   = first_fail_vec_q;
    seen_mask_d        = seen_mask_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d            = ST_RUN;
          err_count_d        = '0;
          first_fail_valid_d = 1'b0;
          first_fail_vec_d   = '0;
          seen_mask_d        = '0;
        end
      end
      ST_RUN: begin
        if (sample_en) begin
          seen_mask_d = seen_next;
          if (mismatch) begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (!first_fail_valid_q) begin
              first_fail_valid_d = 1'b1;
              first_fail_vec_d   = vec;
            end
          end
        end
        if (cov_done || timeout_hit) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ST_IDLE;
      err_count_q        <= '0;
      first_fail_valid_q <= 1'b0;
      first_fail_vec_q   <= '0;
      seen_mask_q        <= '0;
    end else begin
      state_q            <= state_d;
      err_count_q        <= err_count_d;
      first_fail_valid_q <= first_fail_valid_d;
      first_fail_vec_q   <= first_fail_vec_d;
      seen_mask_q        <= seen_mask_d;
    end
  end

  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);
  assign err_count        = err_count_q;
  assign first_fail_valid = first_fail_valid_q;
  assign first_fail_vec   = first_fail_vec_q;
  assign seen_mask        = seen_mask_q;
  assign pass             = done && (err_count_q == '0) && (seen_mask_q == '1) && !timed_out;

endmodule

// File: tb/tb_or_gate_response_checker.sv
// Scoreboard bench for or_gate_response_checker; timeout cases follow CHECKER_TIMEOUT_EN.
module tb_or_gate_response_checker;

  localparam int ERR_W  = 5;
  localparam int TO_CYC = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             vec_valid = 1'b0;
  logic [3:0]       vec = '0;
  logic             obs_e = 1'b0, obs_f = 1'b0, obs_g = 1'b0;
  logic             busy, done, pass, timed_out;
  logic [ERR_W-1:0] err_count;
  logic             first_fail_valid;
  logic [3:0]       first_fail_vec;
  logic [15:0]      seen_mask;

  or_gate_response_checker #(.TIMEOUT_CYCLES(TO_CYC), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec),
    .obs_e(obs_e), .obs_f(obs_f), .obs_g(obs_g),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .err_count(err_count), .first_fail_valid(first_fail_valid),
    .first_fail_vec(first_fail_vec), .seen_mask(seen_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ERR_W-1:0] err;
    logic [15:0]      seen;
    logic             ffv;
    logic [3:0]       ffvec;
    logic             busy;
    logic             done;
    logic             pass;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference state of the checker as the bench expects it
  logic             m_busy, m_done, m_ffv;
  logic [ERR_W-1:0] m_err;
  logic [15:0]      m_seen;
  logic [3:0]       m_ffvec;

  function automatic logic [2:0] gold(input logic [3:0] v);
    return {v[3] | v[2], v[1] | v[0], v[3] | v[2] | v[1] | v[0]};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_ffv = 0; m_err = '0; m_seen = '0; m_ffvec = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; vec_valid = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  // Start pulse with a deliberately wrong sample alongside; it must not count.
  task automatic do_start();
    @(negedge clk);
    start = 1; vec_valid = 1; vec = 4'h3; obs_e = 1; obs_f = 0; obs_g = 0;
    @(posedge clk);
    #1;
    start = 0; vec_valid = 0;
    m_busy = 1; m_done = 0; m_ffv = 0; m_err = '0; m_seen = '0; m_ffvec = '0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL start_state: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    checks++;
    if (err_count !== '0 || seen_mask !== 16'h0 || first_fail_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_clear: err=%0d seen=%h ffv=%b required 0/0000/0", err_count, seen_mask, first_fail_valid);
    end
  endtask

  task automatic send(input logic [3:0] v, input logic e, input logic f, input logic g, input logic st);
    exp_t        x;
    exp_t        got;
    logic [2:0]  gv;
    @(negedge clk);
    vec = v; obs_e = e; obs_f = f; obs_g = g; vec_valid = 1; start = st;
    gv = gold(v);
    if (m_busy) begin
      m_seen[v] = 1'b1;
      if (e !== gv[2] || f !== gv[1] || g !== gv[0]) begin
        if (m_err != {ERR_W{1'b1}}) m_err = m_err + 1'b1;
        if (!m_ffv) begin m_ffv = 1; m_ffvec = v; end
      end
      if (m_seen == 16'hFFFF) begin m_busy = 0; m_done = 1; end
    end
    x.err = m_err; x.seen = m_seen; x.ffv = m_ffv; x.ffvec = m_ffvec;
    x.busy = m_busy; x.done = m_done;
    x.pass = m_done && (m_err == '0) && (m_seen == 16'hFFFF);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    vec_valid = 0; start = 0;
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL sb_empty: queue size 0 required 1");
    end else begin
      got = sb_q.pop_front();
      if (err_count !== got.err || seen_mask !== got.seen || first_fail_valid !== got.ffv ||
          (got.ffv && first_fail_vec !== got.ffvec) || busy !== got.busy || done !== got.done ||
          pass !== got.pass) begin
        errors++;
        $display("FAIL sample_v%h: err=%0d seen=%h ffv=%b ffvec=%h busy=%b done=%b pass=%b required err=%0d seen=%h ffv=%b ffvec=%h busy=%b done=%b pass=%b",
                 v, err_count, seen_mask, first_fail_valid, first_fail_vec, busy, done, pass,
                 got.err, got.seen, got.ffv, got.ffvec, got.busy, got.done, got.pass);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if ({busy, done, pass, timed_out, first_fail_valid} !== 5'b0 || err_count !== '0 ||
        first_fail_vec !== 4'h0 || seen_mask !== 16'h0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b pass=%b to=%b err=%0d ffv=%b ffvec=%h seen=%h required all zero",
               tag, busy, done, pass, timed_out, err_count, first_fail_valid, first_fail_vec, seen_mask);
    end
  endtask

  task automatic sweep_gold();
    logic [2:0] gv;
    for (int i = 0; i < 16; i++) begin
      gv = gold(4'(i));
      send(4'(i), gv[2], gv[1], gv[0], 1'b0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    check_reset_values("reset_values");
  endtask

  task automatic test_full_sweep();
    do_reset();
    do_start();
    sweep_gold();
    checks++;
    if (done !== 1 || busy !== 0 || pass !== 1 || err_count !== '0 || seen_mask !== 16'hFFFF || timed_out !== 0) begin
      errors++;
      $display("FAIL sweep_end: done=%b busy=%b pass=%b err=%0d seen=%h to=%b required 1/0/1/0/ffff/0",
               done, busy, pass, err_count, seen_mask, timed_out);
    end
    // samples in DONE are ignored and all status stays frozen
    send(4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'h0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_stuck_g();
    logic [2:0] gv;
    do_start();  // from DONE
    for (int i = 0; i < 16; i++) begin
      gv = gold(4'(i));
      send(4'(i), gv[2], gv[1], 1'b0, i == 5);
    end
    checks++;
    if (err_count !== 5'd15 || first_fail_vec !== 4'h1 || first_fail_valid !== 1 || pass !== 0 || done !== 1) begin
      errors++;
      $display("FAIL stuck_g: err=%0d ffvec=%h ffv=%b pass=%b done=%b required 15/1/1/0/1",
               err_count, first_fail_vec, first_fail_valid, pass, done);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    do_start();
    for (int i = 0; i < 40; i++) send(4'h8, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err_count !== 5'd31 || seen_mask !== 16'h0100 || busy !== 1 || first_fail_vec !== 4'h8) begin
      errors++;
      $display("FAIL saturate: err=%0d seen=%h busy=%b ffvec=%h required 31/0100/1/8",
               err_count, seen_mask, busy, first_fail_vec);
    end
  endtask

  task automatic test_reset_midrun();
    logic [2:0] gv;
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) begin
      gv = gold(4'(i));
      send(4'(i), ~gv[2], gv[1], gv[0], 1'b0);
    end
    @(negedge clk);
    rst = 1; start = 1;
    @(posedge clk);
    #1;
    check_reset_values("reset_midrun");
    rst = 0; start = 0;
    model_reset();
    do_start();
    sweep_gold();
    checks++;
    if (pass !== 1 || done !== 1) begin
      errors++; $display("FAIL after_reset_sweep: pass=%b done=%b required 1/1", pass, done);
    end
  endtask

  task automatic test_timeout();
    int         n;
    logic [2:0] gv;
    do_reset();
    do_start();
    for (int i = 0; i < 15; i++) begin
      gv = gold(4'(i));
      send(4'(i), gv[2], gv[1], gv[0], 1'b0);
    end
    n = 15;
`ifdef CHECKER_TIMEOUT_EN
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != TO_CYC) begin
      errors++; $display("FAIL timeout_cycle: done at run cycle %0d required %0d", n, TO_CYC);
    end
    checks++;
    if (done !== 1 || busy !== 0 || timed_out !== 1 || pass !== 0 || seen_mask !== 16'h7FFF) begin
      errors++;
      $display("FAIL timeout_state: done=%b busy=%b to=%b pass=%b seen=%h required 1/0/1/0/7fff",
               done, busy, timed_out, pass, seen_mask);
    end
`else
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1 || done !== 0 || timed_out !== 0) begin
        errors++; $display("FAIL no_timeout_c%0d: busy=%b done=%b to=%b required 1/0/0", c, busy, done, timed_out);
      end
    end
`endif
  endtask

  // Coverage completes on RUN cycle TO_CYC, the same edge the timeout would fire.
  task automatic test_cov_wins();
    do_reset();
    do_start();
    repeat (TO_CYC - 16) @(posedge clk);
    sweep_gold();
    checks++;
    if (done !== 1 || timed_out !== 0 || pass !== 1) begin
      errors++; $display("FAIL cov_wins: done=%b to=%b pass=%b required 1/0/1", done, timed_out, pass);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_sweep();
    test_stuck_g();
    test_saturate();
    test_reset_midrun();
    test_timeout();
    test_cov_wins();
    do_reset();
    #1;
    check_reset_values("final_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
